// File: rtl/rr_onehot_arb_mux_pkg.sv
// Shared definitions for the round-robin one-hot arbiter/mux family.
// Optional feature macro used by the top level: RR_ARB_LFSR_EN.
package rr_arb_pkg;

    // Widest requester vector the one-hot encoder helper accepts.
    localparam int MAX_N = 64;

    // Seed and tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11).
    // The register shifts right; the mask selects bits 0,2,3,5, which are
    // the right-shift positions of taps 16,14,13,11.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Width of an encoded requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // One-hot to binary: OR together the indices of all set bits, which
    // for a legal one-hot (or zero) vector is exactly the set position.
    function automatic int oh2idx(input logic [MAX_N-1:0] oh, input int n);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if ((i < n) && oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_onehot_arb_mux_if.sv
// Requester-side and downstream handshake bundle for rr_onehot_arb_mux.
// The slave modport is the arbiter's view; master is the environment's view.
interface rr_onehot_arb_mux_if
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int IDX_W = idx_w(N)
) ();

    logic [N-1:0]          in_valid;
    logic [N-1:0][W-1:0]   in_data;
    logic [N-1:0]          in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_data;
    logic [N-1:0]          out_grant;
    logic [IDX_W-1:0]      out_idx;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_grant,
        output out_idx
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_grant,
        input  out_idx
    );

endinterface

// File: rtl/rr_onehot_arb_mux_pick.sv
// rr_pick: purely combinational rotating-priority find-first.
// Rotates the request vector so ptr lands at bit 0, isolates the lowest set
// bit, then rotates the one-hot back into requester order.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win_oh
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    // Double-width rotate right by ptr, lowest-set-bit isolate, rotate back.
    always_comb begin
        rot    = N'({req, req} >> ptr);
        first  = rot & (~rot + N'(1));
        win_oh = N'(({first, first} << ptr) >> N);
    end

endmodule

// File: rtl/rr_onehot_arb_mux.sv
// rr_onehot_arb_mux: N-way round-robin arbiter with fused payload mux and a
// one-entry registered output stage (full throughput, 1-cycle latency).
// Optional macro RR_ARB_LFSR_EN: priority pointer reloaded from a 16-bit
// LFSR on each transfer instead of advancing past the winner.
// N must be at least 1.
module rr_onehot_arb_mux
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int IDX_W = idx_w(N)
) (
    input  logic               clk,
    input  logic               rst_aL,
    rr_onehot_arb_mux_if.slave bus
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [N-1:0]     win_oh;
    logic [IDX_W-1:0] win_idx;
    logic [MAX_N-1:0] win_wide;
    logic [W-1:0]     win_data;
    logic             can_load;
    logic             xfer;

    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [N-1:0]     out_grant_q;
    logic [IDX_W-1:0] out_idx_q;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.in_valid),
        .ptr    (ptr),
        .win_oh (win_oh)
    );

    // The stage can accept a new entry when empty or being drained this cycle;
    // in_ready is held low during reset so nothing is accepted then.
    assign can_load     = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = win_oh & {N{can_load & rst_aL}};
    assign xfer         = |(bus.in_valid & bus.in_ready);

    assign win_wide = MAX_N'(win_oh);
    assign win_idx  = IDX_W'(oh2idx(win_wide, N));

    // AND-OR payload mux steered directly by the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win_oh[i]) begin
                win_data = win_data | bus.in_data[i];
            end
        end
    end

`ifdef RR_ARB_LFSR_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb  = ^(lfsr & LFSR_TAPS);
    assign ptr_next = IDX_W'(32'(lfsr[IDX_W-1:0]) % N);

    // LFSR advances only on cycles that hand off a request.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            lfsr <= LFSR_SEED;
        end else if (xfer) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    // Step past the winner with an explicit wrap so any N works.
    assign ptr_next = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + 1'b1;
`endif

    // Priority pointer moves only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= ptr_next;
        end
    end

    // Output register: load on transfer, otherwise clear valid on drain;
    // payload, grant and index keep their last values when not loading.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
            out_idx_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= win_data;
            out_grant_q <= win_oh;
            out_idx_q   <= win_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_grant = out_grant_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_rr_onehot_arb_mux.sv
// Self-checking bench for rr_onehot_arb_mux (N=4,W=8 main instance plus
// N=3 and N=1 instances). Honours RR_ARB_LFSR_EN when defined.
module tb_rr_onehot_arb_mux;
    import rr_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int IDX_W = idx_w(N);

    logic clk = 1'b0;
    logic rst_aL;

    rr_onehot_arb_mux_if #(.N(N), .W(W), .IDX_W(IDX_W)) bus ();
    rr_onehot_arb_mux_if #(.N(3), .W(W), .IDX_W(idx_w(3))) b3 ();
    rr_onehot_arb_mux_if #(.N(1), .W(W), .IDX_W(idx_w(1))) b1 ();

    rr_onehot_arb_mux #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus)
    );

    rr_onehot_arb_mux #(.N(3), .W(W), .IDX_W(idx_w(3))) dut3 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (b3)
    );

    rr_onehot_arb_mux #(.N(1), .W(W), .IDX_W(idx_w(1))) dut1 (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (b1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: priority pointer and the single output entry.
    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [N-1:0] m_grant;
    int           m_idx;
    logic [15:0]  m_lfsr;

    // First valid requester scanning upward from p with wrap, -1 if none.
    function automatic int pick_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_in_ready(input logic [N-1:0] v,
                                                  input logic r,
                                                  input logic rs);
        logic [N-1:0] e;
        int w;
        e = '0;
        if (!rs) return e;
        if (m_valid && !r) return e;
        w = pick_winner(v, m_ptr);
        if (w >= 0) e[w] = 1'b1;
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic r, input logic rs);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        rst_aL        = rs;
        #2;
    endtask

    // Advance one clock and update the model from the inputs applied.
    task automatic clock_model();
        int   w;
        logic go;
        w  = pick_winner(bus.in_valid, m_ptr);
        go = rst_aL && (w >= 0) && (!m_valid || bus.out_ready);
        @(posedge clk);
        if (!rst_aL) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_grant = '0;
            m_idx   = 0;
            m_ptr   = 0;
            m_lfsr  = 16'hACE1;
        end else if (go) begin
            m_valid  = 1'b1;
            m_data   = bus.in_data[w];
            m_grant  = '0;
            m_grant[w] = 1'b1;
            m_idx    = w;
`ifdef RR_ARB_LFSR_EN
            m_ptr  = (int'(m_lfsr) % (1 << IDX_W)) % N;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
            m_ptr  = (w + 1) % N;
`endif
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, $urandom, 1'b1, 1'b0);
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_in_ready got=%b exp=0000", bus.in_ready);
            end
            clock_model();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_grant, bus.out_idx} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_out got v=%b d=%h g=%b i=%0d exp all zero",
                         bus.out_valid, bus.out_data, bus.out_grant, bus.out_idx);
            end
        end
    endtask

`ifndef RR_ARB_LFSR_EN
    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 5; c++) begin
            logic [N-1:0] eg;
            eg = '0;
            eg[exp_seq[c]] = 1'b1;
            drive(4'b1111, 32'h33221100, 1'b1, 1'b1);
            clock_model();
            checks++;
            if ({bus.out_valid, bus.out_grant, bus.out_idx, bus.out_data} !==
                {1'b1, eg, IDX_W'(exp_seq[c]), 8'(exp_seq[c] * 8'h11)}) begin
                failures++;
                $display("[TB] FAIL rr_seq c=%0d got g=%b i=%0d d=%h exp g=%b i=%0d",
                         c, bus.out_grant, bus.out_idx, bus.out_data, eg, exp_seq[c]);
            end
        end
    endtask

    task automatic test_alternate();
        int exp_w[4] = '{1, 3, 1, 3};
        drive(4'b0000, 0, 1'b1, 1'b0);
        clock_model();
        for (int c = 0; c < 4; c++) begin
            logic [N-1:0] e;
            e = '0;
            e[exp_w[c]] = 1'b1;
            drive(4'b1010, $urandom, 1'b1, 1'b1);
            checks++;
            if (bus.in_ready !== e) begin
                failures++;
                $display("[TB] FAIL alt_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, e);
            end
            clock_model();
            checks++;
            if ({bus.out_valid, bus.out_idx} !== {1'b1, IDX_W'(exp_w[c])}) begin
                failures++;
                $display("[TB] FAIL alt_idx c=%0d got=%0d exp=%0d", c, bus.out_idx, exp_w[c]);
            end
        end
    endtask

    task automatic test_stall();
        drive(4'b0000, 0, 1'b1, 1'b0);
        clock_model();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 32'h33221100, 1'b1, 1'b1);
            clock_model();
        end
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 32'h33221100, 1'b0, 1'b1);
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL stall_in_ready c=%0d got=%b exp=0000", c, bus.in_ready);
            end
            clock_model();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_idx, bus.out_grant} !==
                {1'b1, 8'h22, IDX_W'(2), 4'b0100}) begin
                failures++;
                $display("[TB] FAIL stall_hold c=%0d got v=%b d=%h i=%0d exp v=1 d=22 i=2",
                         c, bus.out_valid, bus.out_data, bus.out_idx);
            end
        end
        drive(4'b1111, 32'h33221100, 1'b1, 1'b1);
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL release_in_ready got=%b exp=1000", bus.in_ready);
        end
        clock_model();
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_idx} !== {1'b1, 8'h33, IDX_W'(3)}) begin
            failures++;
            $display("[TB] FAIL release_load got d=%h i=%0d exp d=33 i=3",
                     bus.out_data, bus.out_idx);
        end
    endtask

    task automatic test_small_n();
        int   exp3[5] = '{0, 1, 2, 0, 1};
        logic [W-1:0] d1;
        drive(4'b0000, 0, 1'b1, 1'b0);
        b3.in_valid = '0; b1.in_valid = '0;
        clock_model();
        b3.in_data  = {8'hC2, 8'hB1, 8'hA0};
        b3.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(4'b0000, 0, 1'b1, 1'b1);
            b3.in_valid = 3'b111;
            b1.in_valid = (c != 3);
            d1 = 8'($urandom);
            b1.in_data = d1;
            clock_model();
            checks++;
            if ({b3.out_valid, b3.out_idx, b3.out_data} !==
                {1'b1, 2'(exp3[c]), 8'(8'hA0 + exp3[c] * 8'h11)}) begin
                failures++;
                $display("[TB] FAIL n3_seq c=%0d got i=%0d d=%h exp i=%0d",
                         c, b3.out_idx, b3.out_data, exp3[c]);
            end
            checks++;
            if (c != 3 && {b1.out_valid, b1.out_idx, b1.out_data} !== {1'b1, 1'b0, d1}) begin
                failures++;
                $display("[TB] FAIL n1_pipe c=%0d got v=%b i=%0d d=%h exp v=1 i=0 d=%h",
                         c, b1.out_valid, b1.out_idx, b1.out_data, d1);
            end else if (c == 3 && b1.out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL n1_drain got v=%b exp v=0", b1.out_valid);
            end
        end
        b3.in_valid = '0; b1.in_valid = '0;
    endtask
`endif

    task automatic test_reset_midop();
        drive(4'b1111, $urandom, 1'b1, 1'b1);
        clock_model();
        drive(4'b1111, $urandom, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_in_ready got=%b exp=0000", bus.in_ready);
        end
        clock_model();
        checks++;
        if ({bus.out_valid, bus.out_grant, bus.out_idx, bus.out_data} !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_out got v=%b g=%b i=%0d d=%h exp all zero",
                     bus.out_valid, bus.out_grant, bus.out_idx, bus.out_data);
        end
        drive(4'b1000, 32'h44000000, 1'b1, 1'b1);
        clock_model();
        checks++;
        if ({bus.out_valid, bus.out_idx, bus.out_data} !== {1'b1, IDX_W'(3), 8'h44}) begin
            failures++;
            $display("[TB] FAIL midrst_after got v=%b i=%0d d=%h exp v=1 i=3 d=44",
                     bus.out_valid, bus.out_idx, bus.out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v, e;
            logic r, rs;
            v  = N'($urandom);
            r  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 49) != 0);
            drive(v, $urandom, r, rs);
            e = exp_in_ready(v, r, rs);
            checks++;
            if (bus.in_ready !== e || !$onehot0(bus.in_ready)) begin
                failures++;
                $display("[TB] FAIL rand_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, e);
            end
            clock_model();
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_grant, bus.out_idx} !==
                {m_valid, m_data, m_grant, IDX_W'(m_idx)}) begin
                failures++;
                $display("[TB] FAIL rand_out c=%0d got v=%b d=%h g=%b i=%0d exp v=%b d=%h g=%b i=%0d",
                         c, bus.out_valid, bus.out_data, bus.out_grant, bus.out_idx,
                         m_valid, m_data, m_grant, m_idx);
            end
        end
    endtask

`ifdef RR_ARB_LFSR_EN
    task automatic test_lfsr_distribution();
        int cnt[N];
        int seq_a[16];
        int diff;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        drive(4'b0000, 0, 1'b1, 1'b0);
        clock_model();
        for (int c = 0; c < 1000; c++) begin
            drive(4'b1111, $urandom, 1'b1, 1'b1);
            clock_model();
            cnt[int'(bus.out_idx)]++;
            if (c < 16) seq_a[c] = int'(bus.out_idx);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (cnt[i] < 200 || cnt[i] > 300) begin
                failures++;
                $display("[TB] FAIL lfsr_dist idx=%0d got=%0d exp 200..300", i, cnt[i]);
            end
        end
        drive(4'b0000, 0, 1'b1, 1'b0);
        clock_model();
        diff = 0;
        for (int c = 0; c < 16; c++) begin
            drive(4'b1111, $urandom, 1'b1, 1'b1);
            clock_model();
            if (int'(bus.out_idx) != seq_a[c]) diff++;
        end
        checks++;
        if (diff != 0) begin
            failures++;
            $display("[TB] FAIL lfsr_repeat got %0d differing grants exp 0", diff);
        end
    endtask
`endif

    initial begin
        b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b1;
        b1.in_valid = '0; b1.in_data = '0; b1.out_ready = 1'b1;
        test_reset();
`ifndef RR_ARB_LFSR_EN
        test_round_robin();
        test_alternate();
        test_stall();
        test_small_n();
`endif
        test_reset_midop();
        test_random();
`ifdef RR_ARB_LFSR_EN
        test_lfsr_distribution();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arb_mux.md
Name: rr_onehot_arb_mux

Overview:
- Parametrised N-way round-robin arbiter with a fused payload mux and a one-entry registered output stage.
- Replaces ad-hoc shift/mux selection (for example `1 << idx` one-hot generation and packed-array indexing by `sel`) with a fair, back-pressured, one-hot-granting selector.
- Sits in front of shared resources in the OOO core: issue-port sharing, CDB/writeback contention and miss-queue drain.

Parameters:
- N, 4: number of requesters; must be at least 1.
- W, 8: payload width in bits per requester.
- IDX_W, $clog2(N) floored to 1: width of the encoded grant index.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_aL  in  1  reset; synchronous, active-low.
- in_valid  in  N  per-requester valid.
- in_data  in  [N-1:0][W-1:0]  packed per-requester payload.
- in_ready  out  N  per-requester accept; at most one bit set (one-hot or zero).
- out_valid  out  1  registered output holds an entry.
- out_ready  in  1  downstream accept.
- out_data  out  W  registered winning payload.
- out_grant  out  N  registered one-hot of the winner.
- out_idx  out  IDX_W  registered binary index of the winner.

Behaviour:
- Reset (rst_aL==0 at posedge):
  - out_valid=0, out_data=0, out_grant=0, out_idx=0, ptr=0.
  - Any held entry is dropped, including one reset mid-operation.
  - in_ready is 0 while rst_aL==0.
- State:
  - ptr [IDX_W-1:0]: highest-priority requester for the next arbitration.
  - One output register holding valid, data, grant and idx.
- Arbitration (combinational):
  - Scan in_valid starting at ptr, ascending, wrapping N-1 to 0.
  - The first set bit is the winner g; win_oh is the one-hot of g.
  - No valid requesters gives win_oh=0.
- Stage readiness:
  - can_load = ~out_valid | out_ready.
  - in_ready = win_oh & {N{can_load}}.
- Transfer: a request transfers when in_valid[i] & in_ready[i]. On that posedge:
  - out_valid=1, out_data=in_data[g], out_grant=win_oh, out_idx=g.
  - ptr=(g+1) mod N; wrap is explicit, with no reliance on power-of-two N.
- Drain: out_valid & out_ready with no new transfer sets out_valid=0. out_data, out_grant and out_idx hold their stale values.
- Simultaneous drain and load: the new entry overwrites, out_valid stays 1, giving full throughput of 1 grant per cycle.
- Stall: out_valid & ~out_ready.
  - in_ready=0.
  - out_data, out_grant and out_idx stay stable.
  - ptr does not move.
- No requests: ptr holds and the output register follows the drain rule.
- Latency: 1 cycle from an accepted request to out_valid.
- Fairness: a continuously-valid requester waits at most N-1 grants.
- N=1: ptr stays 0, out_idx=0, and the block behaves as a pipeline register.
- in_ready depends combinationally on in_valid and out_ready, never on in_ready. Requesters must not make in_valid depend on in_ready.

Optional Feature:
- Macro: RR_ARB_LFSR_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is reset to 16'hACE1.
  - It steps every cycle that a transfer occurs.
  - On a transfer, ptr is loaded with LFSR[IDX_W-1:0] mod N instead of (g+1) mod N.
  - This gives pseudo-random priority for replacement/victim selection.
- Undefined: strict round-robin as specified above. No LFSR logic is present.

Decomposition:
- Package rr_arb_pkg:
  - function idx_w(n), returning max(1, $clog2(n)).
  - function oh2idx(oh, n).
  - localparams LFSR_SEED=16'hACE1 and LFSR_TAPS.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req[N], ptr.
  - Output: win_oh[N] via double-width rotate, find-first, un-rotate.
  - Reused by later multi-grant arbiters.
- The top level holds ptr, the output register and the handshake.

Test Plan:
- All four valid, in_data={8'h33,8'h22,8'h11,8'h00}, out_ready=1 (N=4, W=8) -> out_idx sequence 0,1,2,3,0 on consecutive cycles; out_grant 0001,0010,0100,1000,0001.
- in_valid=4'b1010 constant, ptr=0 -> winners 1,3,1,3; ptr after each: 2,0,2,0.
- Entry idx2 data 8'h22 held with out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0, out_data=8'h22 stable, ptr=3 unchanged; out_ready=1 then loads idx3 same edge.
- Reset asserted (rst_aL=0) while out_valid=1 -> next edge out_valid=0, ptr=0, out_grant=0; after release, in_valid=4'b1000 -> out_idx=3.
- N=3, all valid, out_ready=1 -> idx 0,1,2,0 (non-power-of-two wrap); N=1 -> out_idx always 0, 1-cycle latency.
- RR_ARB_LFSR_EN defined, all valid, 1000 grants -> each index granted 200–300 times; in_ready always one-hot; seed 16'hACE1 reproduces identical sequence after reset.
